// File: rtl/breath_pkg.sv
// ---------------------------------------------------------------------------
// breath_pkg
// Shared constants and helpers for the rainbow breathing LED sequencer.
//   SPD_L0..SPD_L3   one-hot speed indicator patterns, slowest to fastest
//   COL_R/COL_G/COL_B one-hot colour selects in {b,g,r} order
//   breath_state_t   ramp direction of the brightness state machine
//   level_to_onehot  maps a 2-bit speed level onto its indicator pattern
//   next_colour      advances the colour select R -> G -> B -> R
// ---------------------------------------------------------------------------
package breath_pkg;

    // The board wiring of the speed LEDs is not in physical order, so the
    // indicator patterns are not simply a shifted one-hot.
    localparam logic [3:0] SPD_L0 = 4'b0001;
    localparam logic [3:0] SPD_L1 = 4'b0100;
    localparam logic [3:0] SPD_L2 = 4'b1000;
    localparam logic [3:0] SPD_L3 = 4'b0010;

    localparam logic [2:0] COL_R = 3'b001;
    localparam logic [2:0] COL_G = 3'b010;
    localparam logic [2:0] COL_B = 3'b100;

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } breath_state_t;

    function automatic logic [3:0] level_to_onehot(input logic [1:0] level);
        logic [3:0] onehot;
        case (level)
            2'd0:    onehot = SPD_L0;
            2'd1:    onehot = SPD_L1;
            2'd2:    onehot = SPD_L2;
            default: onehot = SPD_L3;
        endcase
        return onehot;
    endfunction

    // A left rotate of the one-hot word walks R -> G -> B and back to R.
    function automatic logic [2:0] next_colour(input logic [2:0] colour);
        return {colour[1:0], colour[2]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button, filters it with a stability counter and
// emits a single-cycle pulse on each accepted press.
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   i_btn    in   raw, asynchronous, active-high button
//   o_press  out  one-cycle pulse on the debounced 0->1 transition
// ---------------------------------------------------------------------------
module btn_debounce
    import breath_pkg::*;
#(
    parameter int DB_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Two flops bring the asynchronous button into the clock domain before
    // anything else looks at it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while the synchronised sample disagrees with the
    // accepted level; any agreeing sample restarts the window, so a glitch
    // shorter than DB_CYCLES never reaches the accepted level. The press
    // pulse is produced in the same cycle the new high level is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/breath_speed_ctrl.sv
// ---------------------------------------------------------------------------
// breath_speed_ctrl
// Sequencer for the rainbow breathing LED datapath: holds a 4-level speed
// selected by two buttons, ramps a duty word up and down at that speed and
// rotates the active colour once per breath.
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   btn_inc      in   raw speed-up button
//   btn_dec      in   raw slow-down button
//   duty         out  brightness word for the PWM stage
//   color_sel    out  one-hot active colour {b,g,r}
//   led_speed    out  one-hot speed indicator
//   step_tick    out  one-cycle pulse per duty step
//   breath_done  out  one-cycle pulse when a breath ends and colour advances
// ---------------------------------------------------------------------------
module breath_speed_ctrl
    import breath_pkg::*;
#(
    parameter int DUTY_W    = 8,
    parameter int DB_CYCLES = 1250000,
    parameter int DIV_L0    = 245098,
    parameter int DIV_L1    = 122549,
    parameter int DIV_L2    = 61275,
    parameter int DIV_L3    = 30637
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_inc,
    input  logic              btn_dec,
    output logic [DUTY_W-1:0] duty,
    output logic [2:0]        color_sel,
    output logic [3:0]        led_speed,
    output logic              step_tick,
    output logic              breath_done
);

    localparam int DIV_MAX_01 = (DIV_L0 > DIV_L1) ? DIV_L0 : DIV_L1;
    localparam int DIV_MAX_23 = (DIV_L2 > DIV_L3) ? DIV_L2 : DIV_L3;
    localparam int DIV_MAX    = (DIV_MAX_01 > DIV_MAX_23) ? DIV_MAX_01 : DIV_MAX_23;
    localparam int PRE_W      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    logic              w_inc_evt;
    logic              w_dec_evt;
    logic [1:0]        w_level_next;
    logic              w_level_change;
    logic [PRE_W-1:0]  w_div_last;

    logic [1:0]        r_level;
    logic [3:0]        r_led_speed;
    logic [PRE_W-1:0]  r_presc;
    logic              r_step_tick;
    breath_state_t     r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [2:0]        r_color;
    logic              r_breath_done;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_inc),
        .o_press (w_inc_evt)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_dec),
        .o_press (w_dec_evt)
    );

    // Saturating level update; presses on both buttons in the same cycle
    // cancel each other out.
    always_comb begin
        w_level_next = r_level;
        if (w_inc_evt && !w_dec_evt && (r_level != 2'd3)) begin
            w_level_next = r_level + 2'd1;
        end else if (w_dec_evt && !w_inc_evt && (r_level != 2'd0)) begin
            w_level_next = r_level - 2'd1;
        end
    end

    assign w_level_change = (w_level_next != r_level);

    // Terminal prescaler count for the level currently in force.
    always_comb begin
        case (r_level)
            2'd0:    w_div_last = PRE_W'(DIV_L0 - 1);
            2'd1:    w_div_last = PRE_W'(DIV_L1 - 1);
            2'd2:    w_div_last = PRE_W'(DIV_L2 - 1);
            default: w_div_last = PRE_W'(DIV_L3 - 1);
        endcase
    end

    // The indicator is decoded from the next level so it lands in the same
    // cycle as the level register itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level     <= 2'd1;
            r_led_speed <= SPD_L1;
        end else begin
            r_level     <= w_level_next;
            r_led_speed <= level_to_onehot(w_level_next);
        end
    end

    // A level change restarts the step window so the new divider applies
    // from a clean count; a tick that would coincide with it is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_step_tick <= 1'b0;
        end else if (w_level_change) begin
            r_presc     <= '0;
            r_step_tick <= 1'b0;
        end else if (r_presc == w_div_last) begin
            r_presc     <= '0;
            r_step_tick <= 1'b1;
        end else begin
            r_presc     <= r_presc + PRE_W'(1);
            r_step_tick <= 1'b0;
        end
    end

    // Brightness ramp. It reacts to the registered tick, so duty, colour and
    // breath_done move one cycle after the tick is visible. The turn-arounds
    // step straight to MAX-1 and 1 so that the peak and the floor each last
    // a single step, giving 2*DUTY_MAX steps per breath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_UP;
            r_duty        <= '0;
            r_color       <= COL_R;
            r_breath_done <= 1'b0;
        end else begin
            r_breath_done <= 1'b0;
            if (r_step_tick) begin
                case (r_state)
                    ST_UP: begin
                        if (r_duty == DUTY_MAX) begin
                            r_state <= ST_DOWN;
                            r_duty  <= DUTY_MAX - DUTY_W'(1);
                        end else begin
                            r_duty <= r_duty + DUTY_W'(1);
                        end
                    end
                    default: begin
                        if (r_duty == '0) begin
                            r_state       <= ST_UP;
                            r_duty        <= DUTY_W'(1);
                            r_color       <= next_colour(r_color);
                            r_breath_done <= 1'b1;
                        end else begin
                            r_duty <= r_duty - DUTY_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign duty        = r_duty;
    assign color_sel   = r_color;
    assign led_speed   = r_led_speed;
    assign step_tick   = r_step_tick;
    assign breath_done = r_breath_done;

endmodule

// File: tb/tb_breath_speed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_breath_speed_ctrl
// Directed bench for breath_speed_ctrl with a small duty word, a short
// debounce window and dividers 8/4/2/1 so every behaviour is reachable in a
// few hundred cycles.
// ---------------------------------------------------------------------------
module tb_breath_speed_ctrl;

    localparam int DUTY_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              btnInc = 1'b0;
    logic              btnDec = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic [2:0]        colorSel;
    logic [3:0]        ledSpeed;
    logic              stepTick;
    logic              breathDone;

    int vectorCount = 0;
    int missCount   = 0;

    breath_speed_ctrl #(
        .DUTY_W    (DUTY_W),
        .DB_CYCLES (4),
        .DIV_L0    (8),
        .DIV_L1    (4),
        .DIV_L2    (2),
        .DIV_L3    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_inc     (btnInc),
        .btn_dec     (btnDec),
        .duty        (duty),
        .color_sel   (colorSel),
        .led_speed   (ledSpeed),
        .step_tick   (stepTick),
        .breath_done (breathDone)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive both buttons and hold them for the given number of cycles.
    task automatic applyStimulus(input logic inc, input logic dec, input int cycles);
        btnInc = inc;
        btnDec = dec;
        repeat (cycles) stepCycle();
    endtask

    // Press for long enough to register, then release long enough for the
    // release to settle before anything else happens.
    task automatic pressButton(input logic inc, input logic dec);
        applyStimulus(inc, dec, 8);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    // Step until step_tick is seen, returning the number of cycles taken.
    task automatic waitTick(output int waited);
        waited = 1;
        stepCycle();
        while (stepTick !== 1'b1 && waited < 40) begin
            stepCycle();
            waited++;
        end
        if (stepTick !== 1'b1) checkOutput("tick_timeout", {31'b0, stepTick}, 32'd1);
    endtask

    int             nWait;
    logic [DUTY_W-1:0] expDuty;
    logic           expUp;

    initial begin
        $display("[TB] starting breath_speed_ctrl bench");

        // ---------------- 1: reset values and one full breath at level 1
        rst = 1'b0;
        repeat (3) stepCycle();
        checkOutput("t1_rst_led",   ledSpeed,   32'b0100);
        checkOutput("t1_rst_duty",  duty,       32'd0);
        checkOutput("t1_rst_color", colorSel,   32'b001);
        checkOutput("t1_rst_tick",  stepTick,   32'd0);
        checkOutput("t1_rst_done",  breathDone, 32'd0);
        rst = 1'b1;
        repeat (3) stepCycle();
        checkOutput("t1_no_tick_p3", stepTick, 32'd0);
        stepCycle();
        checkOutput("t1_first_tick_p4", stepTick, 32'd1);

        expDuty = '0;
        expUp   = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            if (t > 1) begin
                waitTick(nWait);
                if (t == 2) checkOutput("t1_tick_period", nWait + 1, 32'd4);
            end
            stepCycle();
            if (expUp) begin
                if (expDuty == 3'd7) begin expUp = 1'b0; expDuty = 3'd6; end
                else expDuty = expDuty + 3'd1;
            end else begin
                if (expDuty == 3'd0) begin expUp = 1'b1; expDuty = 3'd1; end
                else expDuty = expDuty - 3'd1;
            end
            checkOutput($sformatf("t1_duty_%0d", t), duty, expDuty);
            if (t == 14) checkOutput("t1_no_done_early", breathDone, 32'd0);
            if (t == 15) begin
                checkOutput("t1_breath_done", breathDone, 32'd1);
                checkOutput("t1_color_g",     colorSel,   32'b010);
            end
        end
        stepCycle();
        checkOutput("t1_done_one_cycle", breathDone, 32'd0);

        // ---------------- 2: held button gives one event; saturation at L3
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("t2_led_before_latency", ledSpeed, 32'b0100);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("t2_led_at_latency", ledSpeed, 32'b1000);
        applyStimulus(1'b1, 1'b0, 13);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("t2_hold_single_event", ledSpeed, 32'b1000);
        pressButton(1'b1, 1'b0);
        checkOutput("t2_second_press_l3", ledSpeed, 32'b0010);
        pressButton(1'b1, 1'b0);
        checkOutput("t2_third_press_sat", ledSpeed, 32'b0010);

        // ---------------- 3: step down to L0 and saturate
        pressButton(1'b0, 1'b1);
        checkOutput("t3_dec1_l2", ledSpeed, 32'b1000);
        pressButton(1'b0, 1'b1);
        checkOutput("t3_dec2_l1", ledSpeed, 32'b0100);
        pressButton(1'b0, 1'b1);
        checkOutput("t3_dec3_l0", ledSpeed, 32'b0001);
        pressButton(1'b0, 1'b1);
        checkOutput("t3_dec4_sat", ledSpeed, 32'b0001);
        waitTick(nWait);
        waitTick(nWait);
        checkOutput("t3_period_l0", nWait, 32'd8);

        // ---------------- 4: glitch rejection and simultaneous presses
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("t4_glitch_ignored", ledSpeed, 32'b0001);
        pressButton(1'b1, 1'b0);
        checkOutput("t4_inc_to_l1", ledSpeed, 32'b0100);
        pressButton(1'b1, 1'b1);
        checkOutput("t4_both_no_change", ledSpeed, 32'b0100);

        // ---------------- 5: level change mid-window restarts the prescaler
        rst = 1'b0;
        repeat (2) stepCycle();
        rst = 1'b1;
        repeat (4) stepCycle();
        checkOutput("t5_tick_p4", stepTick, 32'd1);
        btnInc = 1'b1;
        repeat (6) stepCycle();
        checkOutput("t5_duty_p10", duty, 32'd2);
        checkOutput("t5_led_p10", ledSpeed, 32'b0100);
        stepCycle();
        checkOutput("t5_led_p11", ledSpeed, 32'b1000);
        checkOutput("t5_duty_kept", duty, 32'd2);
        checkOutput("t5_no_tick_p11", stepTick, 32'd0);
        stepCycle();
        checkOutput("t5_no_tick_p12", stepTick, 32'd0);
        stepCycle();
        checkOutput("t5_new_div_tick_p13", stepTick, 32'd1);
        stepCycle();
        checkOutput("t5_dir_up_kept", duty, 32'd3);
        applyStimulus(1'b0, 1'b0, 10);

        // ---------------- 6: async reset mid-DOWN on blue, button held through
        rst = 1'b0;
        repeat (2) stepCycle();
        rst = 1'b1;
        repeat (149) stepCycle();
        checkOutput("t6_pre_duty_down", duty, 32'd5);
        checkOutput("t6_pre_color_b", colorSel, 32'b100);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_duty",  duty,       32'd0);
        checkOutput("t6_async_color", colorSel,   32'b001);
        checkOutput("t6_async_led",   ledSpeed,   32'b0100);
        checkOutput("t6_async_tick",  stepTick,   32'd0);
        checkOutput("t6_async_done",  breathDone, 32'd0);
        btnInc = 1'b1;
        repeat (2) stepCycle();
        rst = 1'b1;
        repeat (6) stepCycle();
        checkOutput("t6_held_no_early_event", ledSpeed, 32'b0100);
        stepCycle();
        checkOutput("t6_held_event_after_window", ledSpeed, 32'b1000);
        applyStimulus(1'b0, 1'b0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/breath_speed_ctrl.md
Name: breath_speed_ctrl

Overview:
Sequencer for the rainbow breathing LED datapath.
- Debounces the speed-up and slow-down buttons and holds a 4-level speed mode.
- Generates the brightness ramp as a duty word with up/down direction.
- Rotates the active colour R→G→B once per breath.
- The downstream PWM stage consumes duty and color_sel. The board drives led_speed directly.

Parameters:
DUTY_W, 8, duty word width; DUTY_MAX = 2^DUTY_W-1
DB_CYCLES, 1250000, cycles a synchronised button level must stay stable to be accepted (10 ms at 125 MHz); minimum 1
DIV_L0, 245098, clk cycles per duty step at level 0 (slowest, 1 s breath at DUTY_W=8)
DIV_L1, 122549, cycles per step at level 1 (0.5 s breath, reset level)
DIV_L2, 61275, cycles per step at level 2 (0.25 s)
DIV_L3, 30637, cycles per step at level 3 (fastest, 0.125 s)

Ports:
clk  in  1  system clock, 125 MHz
rst  in  1  asynchronous, active-low reset
btn_inc  in  1  raw speed-up button, asynchronous, active-high
btn_dec  in  1  raw slow-down button, asynchronous, active-high
duty  out  DUTY_W  current brightness for PWM
color_sel  out  3  one-hot active colour {b,g,r}
led_speed  out  4  one-hot speed indicator
step_tick  out  1  one-cycle pulse on each duty step
breath_done  out  1  one-cycle pulse when a breath completes and colour advances

Behaviour:
- Reset (rst=0, async) values:
  - duty=0, direction UP, color_sel=001
  - level=1, led_speed=0100
  - prescaler=0, step_tick=0, breath_done=0
  - debouncers cleared to released.
- Button path, per button:
  - 2-FF synchroniser feeds a stability counter.
  - The debounced level changes only after DB_CYCLES consecutive equal samples.
  - A press event is a 1-cycle pulse on the debounced 0→1 edge.
  - Holding the button yields exactly one event. Glitches shorter than DB_CYCLES are ignored.
- Speed level, 0..3:
  - inc event: level+1, saturating at 3.
  - dec event: level-1, saturating at 0.
  - inc and dec events in the same cycle: no change.
- led_speed encoding, slow→fast: L0=0001, L1=0100, L2=1000, L3=0010. It is registered and updates the cycle after the event.
- Prescaler:
  - Counts 0..DIV_Ln-1. When the count equals DIV_Ln-1, step_tick=1 for that cycle and the count returns to 0.
  - Any level change forces the prescaler to 0 that cycle. duty, direction and colour are preserved.
- Breath FSM, states UP/DOWN, acts only on step_tick:
  - UP: if duty==DUTY_MAX, go to DOWN and set duty=DUTY_MAX-1. Otherwise duty+1.
  - DOWN: if duty==0, go to UP, set duty=1, rotate color_sel (001→010→100→001) and pulse breath_done. Otherwise duty-1.
  - One breath is exactly 2·DUTY_MAX ticks.
- Timing and latency:
  - All outputs are registered.
  - duty, color_sel and breath_done update on the cycle after the tick they respond to.
  - Raw button to led_speed change is 2 (sync) + DB_CYCLES + 1 cycles.
- Reset asserted mid-breath or mid-debounce: immediate return to the reset values above. A button still held at deassertion produces an event only after a full debounce window.

Decomposition:
- Package breath_pkg holds:
  - speed one-hot constants SPD_L0..SPD_L3
  - colour constants COL_R/COL_G/COL_B
  - the UP/DOWN state enum
  - the level-to-one-hot function
- Sub-module btn_debounce (synchroniser, stability counter, rising-edge pulse, DB_CYCLES parameter) is instantiated twice.

Test Plan:
Bench overrides: DUTY_W=3 (DUTY_MAX=7), DB_CYCLES=4, DIV_L0..L3=8,4,2,1.
1. Reset → led_speed=0100, duty=0, color_sel=001. At level 1, step_tick fires every 4 cycles. duty runs 0..7 then 6..0 in 14 ticks. breath_done pulses and color_sel=010 at the wrap.
2. btn_inc held 20 cycles → exactly one event, led_speed 0100→1000. A second press → 0010. A third press → stays 0010.
3. btn_dec pressed 4 times from L3 → 0010→1000→0100→0001, then stays 0001. The step period becomes 8 cycles.
4. 2-cycle btn_inc glitch → no change. btn_inc and btn_dec pressed simultaneously (same cycles) → no change to led_speed.
5. Level change at prescaler=2 of a DIV=4 window → prescaler restarts at 0 with the new divider. duty value and direction are unchanged across the switch.
6. rst pulled low mid-DOWN with color_sel=100 → all outputs return to reset values asynchronously, before the next clk edge.
